nmr_bstrm_dpath: RTL and testbench

Bitstream datapath that consumes the command words produced by the NMR bitstream sequencer and converts each one into a serial, cycle-accurate output bit stream (pattern, constant-1 or constant-0 segments). It is the receiving end of the `DPATH_START` / `DPATH_BUF_RDY` handshake. It holds one word in a holding buffer while the previous word streams, so consecutive segments play back-to-back without gaps. Its output drives the NMR transmitter/pulse-gating logic.

---
 rtl/nmr_bstrm_pkg.sv | 35 +++
 rtl/nmr_bstrm_buf.sv | 59 +++++
 rtl/nmr_bstrm_dpath.sv | 184 ++++++++++++++++++
 tb/tb_nmr_bstrm_dpath.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmr_bstrm_pkg.sv
// Shared types and helpers for the NMR bitstream datapath.
// Optional feature macro: NMR_BSTRM_UNDERRUN_DET_EN (underrun detection).
package nmr_bstrm_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 120;
    localparam int unsigned HOLD_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        M_PAT  = 2'd0,
        M_ONE  = 2'd1,
        M_ZERO = 2'd2,
        M_END  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PAT   = 2'd1,
        S_CONST = 2'd2,
        S_END   = 2'd3
    } state_e;

    // Priority seq_end > pattern > all-1s > all-0s; no mode bit decodes as all-0s.
    function automatic mode_e decode_mode(input logic seq_end, input logic pat,
                                          input logic one, input logic zero);
        mode_e m;
        casez ({seq_end, pat, one, zero})
            4'b1???: m = M_END;
            4'b01??: m = M_PAT;
            4'b001?: m = M_ONE;
            default: m = M_ZERO;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/nmr_bstrm_buf.sv
// Single-entry holding buffer for sequencer command words.
// Optional feature macro: NMR_BSTRM_UNDERRUN_DET_EN (not used in this file).
module nmr_bstrm_buf
    import nmr_bstrm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  DPATH_START,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  seq_end,
    input  logic                  pattern_mode,
    input  logic                  all_1s_mode,
    input  logic                  all_0s_mode,
    input  logic                  pop_i,
    output logic                  DPATH_BUF_RDY,
    output logic                  buf_full_c,
    output logic [DATA_WIDTH-1:0] buf_data_o,
    output mode_e                 buf_mode_o
);

    logic                  rdy_q, rdy_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    mode_e                 mode_q, mode_d;

    // Capture only into an empty buffer; a promotion frees it.
    always_comb begin
        rdy_d  = rdy_q;
        data_d = data_q;
        mode_d = mode_q;
        if (DPATH_START && rdy_q) begin
            rdy_d  = 1'b0;
            data_d = data_in;
            mode_d = decode_mode(seq_end, pattern_mode, all_1s_mode, all_0s_mode);
        end else if (pop_i) begin
            rdy_d = 1'b1;
        end
    end

    // Buffer registers; reset discards any held word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdy_q  <= 1'b1;
            data_q <= '0;
            mode_q <= M_ZERO;
        end else begin
            rdy_q  <= rdy_d;
            data_q <= data_d;
            mode_q <= mode_d;
        end
    end

    assign DPATH_BUF_RDY = rdy_q;
    assign buf_full_c    = ~rdy_q;
    assign buf_data_o    = data_q;
    assign buf_mode_o    = mode_q;

endmodule

// File: rtl/nmr_bstrm_dpath.sv
// NMR bitstream datapath: turns buffered command words into a serial bit stream.
// Optional feature macro: NMR_BSTRM_UNDERRUN_DET_EN (sticky underrun detection).
module nmr_bstrm_dpath
    import nmr_bstrm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned HOLD_WIDTH = HOLD_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  DPATH_START,
    output logic                  DPATH_BUF_RDY,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  seq_end,
    input  logic                  pattern_mode,
    input  logic                  all_1s_mode,
    input  logic                  all_0s_mode,
    input  logic                  UNDERRUN_CLR,
    output logic                  BSTRM_OUT,
    output logic                  BSTRM_ACTIVE,
    output logic                  SEQ_DONE,
    output logic                  UNDERRUN
);

    logic                  buf_full_c;
    logic [DATA_WIDTH-1:0] buf_data_c;
    mode_e                 buf_mode_c;
    logic [HOLD_WIDTH-1:0] hold_n_c;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [HOLD_WIDTH-1:0] cnt_q, cnt_d;
    logic                  out_q, out_d;
    logic                  active_q, active_d;
    logic                  done_q, done_d;
    logic                  seg_end_c, promote_c, starved_c, set_inseq_c, clr_inseq_c;

    nmr_bstrm_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .CLK          (CLK),
        .RST          (RST),
        .DPATH_START  (DPATH_START),
        .data_in      (data_in),
        .seq_end      (seq_end),
        .pattern_mode (pattern_mode),
        .all_1s_mode  (all_1s_mode),
        .all_0s_mode  (all_0s_mode),
        .pop_i        (promote_c),
        .DPATH_BUF_RDY(DPATH_BUF_RDY),
        .buf_full_c   (buf_full_c),
        .buf_data_o   (buf_data_c),
        .buf_mode_o   (buf_mode_c)
    );

    assign hold_n_c = buf_data_c[HOLD_WIDTH-1:0];

    // Next state: cnt_q counts remaining cycles of the segment including the current one.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        out_d       = 1'b0;
        active_d    = 1'b0;
        done_d      = 1'b0;
        seg_end_c   = 1'b0;
        promote_c   = 1'b0;
        starved_c   = 1'b0;
        set_inseq_c = 1'b0;
        clr_inseq_c = 1'b0;

        case (state_q)
            S_IDLE:  promote_c = buf_full_c;
            S_PAT: begin
                if (cnt_q == HOLD_WIDTH'(1)) begin
                    seg_end_c = 1'b1;
                end else begin
                    cnt_d    = cnt_q - HOLD_WIDTH'(1);
                    out_d    = shreg_q[DATA_WIDTH-1];
                    shreg_d  = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                    active_d = 1'b1;
                end
            end
            S_CONST: begin
                if (cnt_q == HOLD_WIDTH'(1)) begin
                    seg_end_c = 1'b1;
                end else begin
                    cnt_d    = cnt_q - HOLD_WIDTH'(1);
                    out_d    = out_q;
                    active_d = 1'b1;
                end
            end
            S_END:   state_d = S_IDLE;
        endcase

        if (seg_end_c) begin
            if (buf_full_c) begin
                promote_c = 1'b1;
            end else begin
                state_d   = S_IDLE;
                starved_c = 1'b1;
            end
        end

        if (promote_c) begin
            case (buf_mode_c)
                M_END: begin
                    state_d     = S_END;
                    done_d      = 1'b1;
                    clr_inseq_c = 1'b1;
                end
                M_PAT: begin
                    state_d     = S_PAT;
                    out_d       = buf_data_c[DATA_WIDTH-1];
                    shreg_d     = {buf_data_c[DATA_WIDTH-2:0], 1'b0};
                    cnt_d       = HOLD_WIDTH'(DATA_WIDTH);
                    active_d    = 1'b1;
                    set_inseq_c = 1'b1;
                end
                default: begin
                    state_d     = S_CONST;
                    out_d       = (buf_mode_c == M_ONE);
                    cnt_d       = (hold_n_c == '0) ? HOLD_WIDTH'(1) : hold_n_c;
                    active_d    = 1'b1;
                    set_inseq_c = 1'b1;
                end
            endcase
        end
    end

    // Streaming state and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign BSTRM_OUT    = out_q;
    assign BSTRM_ACTIVE = active_q;
    assign SEQ_DONE     = done_q;

`ifdef NMR_BSTRM_UNDERRUN_DET_EN
    logic inseq_q, inseq_d;
    logic underrun_q, underrun_d;

    // In-sequence tracking and sticky underrun; a new underrun beats a coincident clear.
    always_comb begin
        inseq_d    = inseq_q;
        underrun_d = underrun_q;
        if (set_inseq_c) inseq_d = 1'b1;
        if (clr_inseq_c) inseq_d = 1'b0;
        if (UNDERRUN_CLR) underrun_d = 1'b0;
        if (starved_c && inseq_q) underrun_d = 1'b1;
    end

    // Underrun bookkeeping registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inseq_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            inseq_q    <= inseq_d;
            underrun_q <= underrun_d;
        end
    end

    assign UNDERRUN = underrun_q;
`else
    logic unused_cfg_c;
    assign unused_cfg_c = ^{UNDERRUN_CLR, starved_c, set_inseq_c, clr_inseq_c};
    assign UNDERRUN     = 1'b0;
`endif

endmodule

// File: tb/tb_nmr_bstrm_dpath.sv
// Scoreboard bench for nmr_bstrm_dpath: stimulus pushes expected bits, a monitor pops them.
module tb_nmr_bstrm_dpath;

    localparam int unsigned DW = 120;
    localparam int unsigned HW = 32;
`ifdef NMR_BSTRM_UNDERRUN_DET_EN
    localparam logic UR_EN = 1'b1;
`else
    localparam logic UR_EN = 1'b0;
`endif

    logic          CLK, RST;
    logic          DPATH_START, DPATH_BUF_RDY;
    logic [DW-1:0] data_in;
    logic          seq_end, pattern_mode, all_1s_mode, all_0s_mode;
    logic          UNDERRUN_CLR;
    logic          BSTRM_OUT, BSTRM_ACTIVE, SEQ_DONE, UNDERRUN;

    typedef struct packed {
        logic is_done;
        logic val;
    } ev_t;

    ev_t exp_q[$];
    int  checks    = 0;
    int  errors    = 0;
    int  bits_seen = 0;
    int  run_len   = 0;
    int  last_run  = 0;

    nmr_bstrm_dpath #(.DATA_WIDTH(DW), .HOLD_WIDTH(HW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .DPATH_START  (DPATH_START),
        .DPATH_BUF_RDY(DPATH_BUF_RDY),
        .data_in      (data_in),
        .seq_end      (seq_end),
        .pattern_mode (pattern_mode),
        .all_1s_mode  (all_1s_mode),
        .all_0s_mode  (all_0s_mode),
        .UNDERRUN_CLR (UNDERRUN_CLR),
        .BSTRM_OUT    (BSTRM_OUT),
        .BSTRM_ACTIVE (BSTRM_ACTIVE),
        .SEQ_DONE     (SEQ_DONE),
        .UNDERRUN     (UNDERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // Reference model: expand one accepted word into the bits it must produce.
    task automatic model_push(input logic [DW-1:0] d, input logic se, input logic pm,
                              input logic o1);
        ev_t e;
        int  n;
        if (se) begin
            e.is_done = 1'b1; e.val = 1'b0;
            exp_q.push_back(e);
        end else if (pm) begin
            for (int i = DW - 1; i >= 0; i--) begin
                e.is_done = 1'b0; e.val = d[i];
                exp_q.push_back(e);
            end
        end else begin
            n = int'(d[HW-1:0]);
            if (n == 0) n = 1;
            for (int i = 0; i < n; i++) begin
                e.is_done = 1'b0; e.val = o1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic se, input logic pm,
                             input logic o1, input logic o0);
        int w = 0;
        @(negedge CLK);
        while (!DPATH_BUF_RDY && w < 500) begin
            @(negedge CLK);
            w++;
        end
        if (!DPATH_BUF_RDY) begin
            fail_now("send_timeout", "buffer never became ready");
            return;
        end
        data_in = d; seq_end = se; pattern_mode = pm; all_1s_mode = o1; all_0s_mode = o0;
        DPATH_START = 1'b1;
        @(posedge CLK);
        #1;
        DPATH_START = 1'b0;
        seq_end = 1'b0; pattern_mode = 1'b0; all_1s_mode = 1'b0; all_0s_mode = 1'b0;
        model_push(d, se, pm, o1);
    endtask

    task automatic wait_idle(input string name);
        int w = 0;
        do begin
            @(negedge CLK);
            #1;
            w++;
        end while ((exp_q.size() != 0 || BSTRM_ACTIVE || SEQ_DONE || !DPATH_BUF_RDY) && w < 3000);
        if (w >= 3000) fail_now(name, "stream did not drain");
    endtask

    task automatic pulse_clr();
        @(negedge CLK);
        UNDERRUN_CLR = 1'b1;
        @(posedge CLK);
        #1;
        UNDERRUN_CLR = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] const_word(input int n);
        logic [DW-1:0] d;
        d = rand_word();
        d[HW-1:0] = HW'(n);
        return d;
    endfunction

    // Monitor: every active cycle consumes one expected bit, every SEQ_DONE one done event.
    always @(negedge CLK) begin
        ev_t ev;
        if (!RST) begin
            if (BSTRM_ACTIVE && SEQ_DONE) fail_now("active_with_done", "both high");
            if (BSTRM_ACTIVE) begin
                bits_seen++;
                run_len++;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_bit", "active with nothing expected");
                end else begin
                    ev = exp_q.pop_front();
                    check("stream_bit", {ev.is_done, BSTRM_OUT}, {1'b0, ev.val});
                end
            end else begin
                check("idle_out_zero", BSTRM_OUT, 1'b0);
                if (run_len > 0) begin
                    last_run = run_len;
                    run_len  = 0;
                end
            end
            if (SEQ_DONE) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done", "SEQ_DONE with nothing expected");
                end else begin
                    ev = exp_q.pop_front();
                    check("seq_done_order", ev.is_done, 1'b1);
                end
            end
        end else begin
            run_len = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        int            base, w;
        logic [3:0]    m;

        RST = 1'b1; DPATH_START = 1'b0; data_in = '0; seq_end = 1'b0;
        pattern_mode = 1'b0; all_1s_mode = 1'b0; all_0s_mode = 1'b0; UNDERRUN_CLR = 1'b0;

        // Reset values
        #12;
        check("rst_buf_rdy", DPATH_BUF_RDY, 1'b1);
        check("rst_out", {BSTRM_OUT, BSTRM_ACTIVE, SEQ_DONE, UNDERRUN}, 4'b0000);
        @(negedge CLK); #2 RST = 1'b0;

        // Pattern word: four ones then 116 zeros, with capture/promotion latency
        d = {4'hF, 116'd0};
        send_word(d, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        check("cap_rdy_low", DPATH_BUF_RDY, 1'b0);
        check("cap_not_active", BSTRM_ACTIVE, 1'b0);
        @(negedge CLK);
        check("promo_active", BSTRM_ACTIVE, 1'b1);
        check("promo_rdy_high", DPATH_BUF_RDY, 1'b1);
        check("promo_first_bit", BSTRM_OUT, 1'b1);
        wait_idle("pat_drain");
        check("pat_run_len", last_run, 120);
        check("pat_underrun", UNDERRUN, UR_EN);
        pulse_clr();
        check("clr_after_pat", UNDERRUN, 1'b0);

        // all-1s N=5 then all-0s N=3 back to back, then all-0s N=0
        send_word(const_word(5), 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(const_word(3), 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle("const_drain");
        check("const_run_len", last_run, 8);
        send_word(const_word(0), 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle("zero_n_drain");
        check("zero_n_run_len", last_run, 1);
        pulse_clr();

        // all-1s N=2 ended by a seq_end word
        send_word(const_word(2), 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(rand_word(), 1'b1, 1'b1, 1'b0, 1'b0);
        w = 0;
        do begin
            @(negedge CLK); #1; w++;
        end while (!SEQ_DONE && w < 50);
        if (!SEQ_DONE) fail_now("seq_done_wait", "SEQ_DONE never asserted");
        check("done_inactive", {BSTRM_ACTIVE, BSTRM_OUT}, 2'b00);
        check("done_run_len", last_run, 2);
        @(negedge CLK); #1;
        check("done_one_cycle", SEQ_DONE, 1'b0);
        check("done_no_underrun", UNDERRUN, 1'b0);

        // Underrun: all-1s N=1 with no follow-up, then a normal word, then clear
        send_word(const_word(1), 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle("ur_drain");
        check("ur_set", UNDERRUN, UR_EN);
        check("ur_out_zero", BSTRM_OUT, 1'b0);
        send_word(const_word(2), 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle("ur_resume");
        check("ur_resume_len", last_run, 2);
        check("ur_sticky", UNDERRUN, UR_EN);
        pulse_clr();
        check("ur_cleared", UNDERRUN, 1'b0);

        // DPATH_START while the buffer is full is ignored
        send_word(const_word(6), 1'b0, 1'b0, 1'b1, 1'b0);
        data_in = rand_word(); pattern_mode = 1'b1; DPATH_START = 1'b1;
        @(posedge CLK); #1;
        DPATH_START = 1'b0; pattern_mode = 1'b0;
        check("ignored_buf_empty", DPATH_BUF_RDY, 1'b1);
        wait_idle("ignored_drain");
        check("ignored_run_len", last_run, 6);

        // Reset at bit 60 of a pattern with a second word buffered
        send_word(rand_word(), 1'b0, 1'b1, 1'b0, 1'b0);
        base = bits_seen;
        send_word(const_word(3), 1'b0, 1'b0, 1'b1, 1'b0);
        w = 0;
        while (bits_seen < base + 60 && w < 500) begin
            @(negedge CLK); w++;
        end
        if (bits_seen < base + 60) fail_now("rst_wait", "pattern never reached bit 60");
        #2 RST = 1'b1;
        #1;
        check("midrst_buf_rdy", DPATH_BUF_RDY, 1'b1);
        check("midrst_out", {BSTRM_OUT, BSTRM_ACTIVE, SEQ_DONE, UNDERRUN}, 4'b0000);
        exp_q.delete();
        @(negedge CLK); @(negedge CLK); #2 RST = 1'b0;
        repeat (6) @(negedge CLK);
        #1;
        check("midrst_stays_idle", {BSTRM_ACTIVE, DPATH_BUF_RDY}, 2'b01);

        // Randomized words with all mode-bit combinations and random spacing
        for (int i = 0; i < 60; i++) begin
            m = 4'($urandom_range(0, 15));
            if (m[2]) d = rand_word();
            else d = const_word(int'($urandom_range(0, 8)));
            send_word(d, m[3], m[2], m[1], m[0]);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        wait_idle("rand_drain");
        check("rand_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
